ex_result_forward: RTL and testbench

- Return path of the ALU operand network. Captures each EX-stage result into a MEM-stage register, then a WB-stage register.
- Compares in-flight destinations against the decode-stage source registers and drives forward-select codes and forward data to the ALU A/B operand muxes.
- Detects load-use hazards and drives the register-file write port.

---
 rtl/ex_result_forward.sv | 188 ++++++++++++++++++
 tb/tb_ex_result_forward.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_forward.sv
// ex_result_forward
//   Return path of the ALU operand network. Each EX result is captured into a
//   MEM-stage register and then a WB-stage register. In-flight destinations
//   are compared against the decode-stage sources to drive the ALU A/B
//   forward muxes. The block also flags load-use hazards and drives the
//   register-file write port.
//
// Optional build macro:
//   FWD_WB_BYPASS_EN  when defined, WB-stage forwarding is enabled (sel=10).
//                     When undefined, only sel=00/01 occur, and the register
//                     file must write through in the same cycle.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   ex_valid/ex_we/ex_is_load       EX-stage instruction attributes
//   ex_rd, ex_result                EX destination and ALU result (address for loads)
//   mem_rdata                       load data for the MEM-stage instruction
//   stall                           freeze both pipeline registers
//   flush                           kill the instruction entering MEM (beats stall)
//   id_ra/id_rb, id_r*_used         decode-stage sources and their use flags
//   fwd_{a,b}_sel                   00 regfile, 01 MEM result, 10 WB data
//   fwd_{a,b}_data                  selected forward value, 0 when sel=00
//   load_use_stall                  decode must hold one cycle
//   wb_we/wb_rd/wb_data             register-file write port (registered)

// Per-operand compare/select. MEM wins over WB because it holds the newer
// producer. mem_match is exported so the top can build the load-use term.
module ex_fwd_lane #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          mem_ok,      // MEM entry may forward (valid, writes, not a load)
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_ok,       // WB entry may forward
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic [RW-1:0] src_rd,
  input  logic          src_used,
  output logic [1:0]    sel,
  output logic [DW-1:0] data,
  output logic          mem_match
);
  always_comb begin
    mem_match = src_used & (mem_rd == src_rd);
    sel       = 2'b00;
    data      = '0;
    if (mem_ok & mem_match) begin
      sel  = 2'b01;
      data = mem_result;
    end else if (wb_ok & src_used & (wb_rd == src_rd)) begin
      sel  = 2'b10;
      data = wb_data;
    end
  end
endmodule

module ex_result_forward #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [RW-1:0] ex_rd,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] mem_rdata,
  input  logic          stall,
  input  logic          flush,
  input  logic [RW-1:0] id_ra,
  input  logic [RW-1:0] id_rb,
  input  logic          id_ra_used,
  input  logic          id_rb_used,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic [DW-1:0] fwd_a_data,
  output logic [DW-1:0] fwd_b_data,
  output logic          load_use_stall,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);
  localparam int STAGES  = 2;   // 1 = MEM, 2 = WB
  localparam int NUM_OPS = 2;   // 0 = A, 1 = B

`ifdef FWD_WB_BYPASS_EN
  localparam logic WB_FWD_EN = 1'b1;
`else
  // Tied off rather than removed so the WB compare folds away in synthesis.
  localparam logic WB_FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic          is_load;
    logic [RW-1:0] rd;
    logic [DW-1:0] result;
  } mem_st_t;

  typedef struct packed {
    logic          we;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_st_t;

  logic [STAGES:1] vld_pipe_d, vld_pipe_q;
  mem_st_t         mem_d, mem_q;
  wb_st_t          wb_d, wb_q;

  // Pipeline registers. On flush only the MEM valid is dropped; the payload
  // is left alone since nothing downstream looks at it without the valid.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    mem_d      = mem_q;
    wb_d       = wb_q;
    if (flush) begin
      vld_pipe_d[1] = 1'b0;
    end else if (!stall) begin
      vld_pipe_d[1] = ex_valid;
      mem_d.we      = ex_we;
      mem_d.is_load = ex_is_load;
      mem_d.rd      = ex_rd;
      mem_d.result  = ex_result;
    end
    if (!stall) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      wb_d.we       = vld_pipe_q[1] & mem_q.we;
      wb_d.rd       = mem_q.rd;
      wb_d.data     = mem_q.is_load ? mem_rdata : mem_q.result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
    end
  end

  // Loads have no data in MEM yet, so they never forward from there.
  logic mem_ok, wb_ok;
  assign mem_ok = vld_pipe_q[1] & mem_q.we & ~mem_q.is_load;
  assign wb_ok  = WB_FWD_EN & vld_pipe_q[2] & wb_q.we;

  logic [NUM_OPS-1:0][RW-1:0] src_rd;
  logic [NUM_OPS-1:0]         src_used;
  logic [NUM_OPS-1:0][1:0]    sel;
  logic [NUM_OPS-1:0][DW-1:0] data;
  logic [NUM_OPS-1:0]         mem_match;

  assign src_rd   = {id_rb, id_ra};
  assign src_used = {id_rb_used, id_ra_used};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_lane
    ex_fwd_lane #(.DW(DW), .RW(RW)) u_lane (
      .mem_ok     (mem_ok),
      .mem_rd     (mem_q.rd),
      .mem_result (mem_q.result),
      .wb_ok      (wb_ok),
      .wb_rd      (wb_q.rd),
      .wb_data    (wb_q.data),
      .src_rd     (src_rd[g]),
      .src_used   (src_used[g]),
      .sel        (sel[g]),
      .data       (data[g]),
      .mem_match  (mem_match[g])
    );
  end

  assign fwd_a_sel  = sel[0];
  assign fwd_b_sel  = sel[1];
  assign fwd_a_data = data[0];
  assign fwd_b_data = data[1];

  // A load in MEM feeding decode: hold one cycle, then it forwards from WB.
  assign load_use_stall = vld_pipe_q[1] & mem_q.we & mem_q.is_load & (|mem_match);

  assign wb_we   = wb_q.we;
  assign wb_rd   = wb_q.rd;
  assign wb_data = wb_q.data;
endmodule

// File: tb/tb_ex_result_forward.sv
// Scoreboard bench for ex_result_forward. Stimulus pushes hand-computed
// expectations; a monitor pops and compares them on the falling edge (or
// right away, via chk_ev, for the asynchronous reset case).
module tb_ex_result_forward;
  localparam int DW = 16;
  localparam int RW = 4;

`ifdef FWD_WB_BYPASS_EN
  localparam bit WBF = 1'b1;
`else
  localparam bit WBF = 1'b0;
`endif
  localparam logic [1:0] S_WB = WBF ? 2'b10 : 2'b00;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          ex_valid, ex_we, ex_is_load, stall, flush;
  logic [RW-1:0] ex_rd, id_ra, id_rb;
  logic [DW-1:0] ex_result, mem_rdata;
  logic          id_ra_used, id_rb_used;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [DW-1:0] fwd_a_data, fwd_b_data, wb_data;
  logic          load_use_stall, wb_we;
  logic [RW-1:0] wb_rd;

  always #5 clk = ~clk;

  ex_result_forward #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result), .mem_rdata(mem_rdata),
    .stall(stall), .flush(flush),
    .id_ra(id_ra), .id_rb(id_rb), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .load_use_stall(load_use_stall),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct {
    string       name;
    logic [1:0]  sa, sb;
    logic [15:0] da, db;
    logic        lus, we;
    logic [3:0]  rd;
    logic [15:0] wd;
    bit          exact;   // compare wb_rd/wb_data even when wb_we=0
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  event chk_ev;

  function automatic logic [15:0] wbd(input logic [15:0] d);
    return WBF ? d : 16'h0000;
  endfunction

  task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic push(input string n, input logic [1:0] sa, input logic [15:0] da,
                      input logic [1:0] sb, input logic [15:0] db, input logic lus,
                      input logic we, input logic [3:0] rd, input logic [15:0] wd,
                      input bit exact = 1'b0);
    exp_t e;
    e.name = n; e.sa = sa; e.da = da; e.sb = sb; e.db = db;
    e.lus = lus; e.we = we; e.rd = rd; e.wd = wd; e.exact = exact;
    q.push_back(e);
  endtask

  task automatic cyc(input string n, input logic [1:0] sa, input logic [15:0] da,
                     input logic [1:0] sb, input logic [15:0] db, input logic lus,
                     input logic we, input logic [3:0] rd, input logic [15:0] wd,
                     input bit exact = 1'b0);
    push(n, sa, da, sb, db, lus, we, rd, wd, exact);
    @(posedge clk); #1;
  endtask

  task automatic ex_drv(input logic v, input logic we, input logic ld,
                        input logic [3:0] rd, input logic [15:0] res);
    ex_valid = v; ex_we = we; ex_is_load = ld; ex_rd = rd; ex_result = res;
  endtask

  task automatic id_drv(input logic [3:0] ra, input logic rau,
                        input logic [3:0] rb, input logic rbu);
    id_ra = ra; id_ra_used = rau; id_rb = rb; id_rb_used = rbu;
  endtask

  task automatic idle();
    ex_drv(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    id_drv(4'd0, 1'b0, 4'd0, 1'b0);
    stall = 1'b0; flush = 1'b0; mem_rdata = 16'h0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp($sformatf("%s/fwd_a", e.name), {14'h0, fwd_a_sel, fwd_a_data}, {14'h0, e.sa, e.da});
        cmp($sformatf("%s/fwd_b", e.name), {14'h0, fwd_b_sel, fwd_b_data}, {14'h0, e.sb, e.db});
        cmp($sformatf("%s/load_use", e.name), {31'h0, load_use_stall}, {31'h0, e.lus});
        if (e.exact || e.we)
          cmp($sformatf("%s/wb", e.name), {11'h0, wb_we, wb_rd, wb_data}, {11'h0, e.we, e.rd, e.wd});
        else
          cmp($sformatf("%s/wb_we", e.name), {31'h0, wb_we}, 32'h0);
      end
    end
  end

  initial begin
    idle();
    #1 push("reset", 2'b00, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back dependency
    ex_drv(1, 1, 0, 4'd3, 16'h1234);
    cyc("b2b_c1", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    ex_drv(0, 0, 0, 4'd0, 16'h0); id_drv(4'd1, 1, 4'd3, 1);
    cyc("b2b_fwd", 2'b00, 16'h0, 2'b01, 16'h1234, 0, 0, 0, 0);
    id_drv(0, 0, 0, 0);
    cyc("b2b_wb", 0, 0, 0, 0, 0, 1, 4'd3, 16'h1234);

    // distance-2 dependency
    ex_drv(1, 1, 0, 4'd5, 16'h00FF);
    cyc("d2_c1", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(1, 1, 0, 4'd7, 16'h0777);
    cyc("d2_c2", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(0, 0, 0, 4'd0, 16'h0); id_drv(4'd5, 1, 4'd0, 0);
    cyc("d2_fwd", S_WB, wbd(16'h00FF), 0, 0, 0, 1, 4'd5, 16'h00FF);
    id_drv(0, 0, 0, 0);
    cyc("d2_wb", 0, 0, 0, 0, 0, 1, 4'd7, 16'h0777);

    // MEM beats WB
    ex_drv(1, 1, 0, 4'd2, 16'h1111);
    cyc("pri_c1", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(1, 1, 0, 4'd2, 16'h2222);
    cyc("pri_c2", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(0, 0, 0, 4'd0, 16'h0); id_drv(4'd2, 1, 4'd2, 1);
    cyc("pri_fwd", 2'b01, 16'h2222, 2'b01, 16'h2222, 0, 1, 4'd2, 16'h1111);
    id_drv(0, 0, 0, 0);
    cyc("pri_wb", 0, 0, 0, 0, 0, 1, 4'd2, 16'h2222);

    // load-use
    ex_drv(1, 1, 1, 4'd4, 16'h0040);
    cyc("ld_c1", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(0, 0, 0, 4'd0, 16'h0); id_drv(4'd4, 1, 4'd0, 0); mem_rdata = 16'hBEEF;
    cyc("ld_use", 0, 0, 0, 0, 1, 0, 0, 0);
    mem_rdata = 16'h0;
    cyc("ld_fwd", S_WB, wbd(16'hBEEF), 0, 0, 0, 1, 4'd4, 16'hBEEF);

    // flush: r6 must never write
    id_drv(0, 0, 0, 0); ex_drv(1, 1, 0, 4'd6, 16'h6666); flush = 1;
    cyc("fl_c1", 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 0; ex_drv(0, 0, 0, 4'd0, 16'h0); id_drv(4'd6, 1, 4'd0, 0);
    cyc("fl_fwd", 0, 0, 0, 0, 0, 0, 0, 0);
    id_drv(0, 0, 0, 0);
    cyc("fl_wb", 0, 0, 0, 0, 0, 0, 0, 0);

    // stall holds everything for three cycles
    ex_drv(1, 1, 0, 4'd8, 16'h0888);
    cyc("st_c1", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(1, 1, 0, 4'd9, 16'h0999);
    cyc("st_c2", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(0, 0, 0, 4'd0, 16'h0); stall = 1; id_drv(4'd9, 1, 4'd8, 1);
    cyc("st_h0", 2'b01, 16'h0999, S_WB, wbd(16'h0888), 0, 1, 4'd8, 16'h0888);
    ex_drv(1, 1, 0, 4'd10, 16'hAAAA);
    cyc("st_h1", 2'b01, 16'h0999, S_WB, wbd(16'h0888), 0, 1, 4'd8, 16'h0888);
    cyc("st_h2", 2'b01, 16'h0999, S_WB, wbd(16'h0888), 0, 1, 4'd8, 16'h0888);
    stall = 0; ex_drv(0, 0, 0, 4'd0, 16'h0);
    cyc("st_rel", 2'b01, 16'h0999, S_WB, wbd(16'h0888), 0, 1, 4'd8, 16'h0888);
    cyc("st_wb", S_WB, wbd(16'h0999), 0, 0, 0, 1, 4'd9, 16'h0999);

    // stall and flush together: MEM dropped, WB held
    id_drv(0, 0, 0, 0); ex_drv(1, 1, 0, 4'd11, 16'h0BBB);
    cyc("sf_c1", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(1, 1, 0, 4'd12, 16'h0CCC);
    cyc("sf_c2", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(0, 0, 0, 4'd0, 16'h0); stall = 1; flush = 1;
    cyc("sf_both", 0, 0, 0, 0, 0, 1, 4'd11, 16'h0BBB);
    stall = 0; flush = 0; id_drv(4'd12, 1, 4'd0, 0);
    cyc("sf_inv", 0, 0, 0, 0, 0, 1, 4'd11, 16'h0BBB);
    id_drv(0, 0, 0, 0);
    cyc("sf_wb", 0, 0, 0, 0, 0, 0, 0, 0);

    // asynchronous reset mid-stream
    ex_drv(1, 1, 0, 4'd13, 16'h0DDD);
    cyc("rs_c1", 0, 0, 0, 0, 0, 0, 0, 0);
    ex_drv(1, 1, 0, 4'd14, 16'h0EEE); id_drv(4'd13, 1, 4'd0, 0);
    cyc("rs_c2", 2'b01, 16'h0DDD, 0, 0, 0, 0, 0, 0);
    ex_drv(0, 0, 0, 4'd0, 16'h0); id_drv(4'd14, 1, 4'd13, 1);
    push("rs_c3", 2'b01, 16'h0EEE, S_WB, wbd(16'h0DDD), 0, 1, 4'd13, 16'h0DDD);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 push("rs_async", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    -> chk_ev;
    @(posedge clk); #1;
    push("rs_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc("rs_after", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    cyc("rs_after2", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);

    @(negedge clk); #1;
    cmp("drain", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
